chrom_serial_loader: RTL and testbench

// - Serial-to-parallel genotype loader feeding the evolvable LUT grid (newGenetico).
// - Deserialises one chromosome bit-stream into the grid's truth tables (saidas_LE) and output-mux selectors (out_chrom).
// - Double-buffered: the grid sees only committed, complete genotypes and never a partial frame.

---
 rtl/chrom_serial_loader_pkg.sv | 21 ++
 rtl/chrom_serial_loader_sel_check.sv | 27 ++
 rtl/chrom_serial_loader.sv | 147 ++++++++++++++
 tb/tb_chrom_serial_loader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chrom_serial_loader_pkg.sv
// Shared parameter set and loader-state type for the evolvable LUT grid
// genotype path (loader and GA controller).
package chrom_serial_loader_pkg;

    localparam int ROW   = 4;                   // grid rows
    localparam int COL   = 4;                   // grid columns
    localparam int IN    = 4;                   // circuit inputs (parameter-set consistency)
    localparam int OUT   = 2;                   // circuit outputs = number of selectors

    localparam int SELW  = $clog2(ROW * COL);   // selector width
    localparam int CELLW = ROW * COL * 16;      // truth-table payload bits
    localparam int TOTAL = CELLW + OUT * SELW;  // payload bits per frame

    typedef enum logic [1:0] {
        LD_IDLE   = 2'd0,
        LD_SHIFT  = 2'd1,
        LD_CHECK  = 2'd2,
        LD_COMMIT = 2'd3
    } loader_state_t;

endpackage

// File: rtl/chrom_serial_loader_sel_check.sv
// chrom_sel_check: combinational range check of every output-mux selector
// against the number of grid cells. Flags the frame if any selector points
// past the last cell.
module chrom_sel_check #(
    parameter int NSEL  = 2,
    parameter int SELW  = 4,
    parameter int LIMIT = 16
) (
    input  logic [NSEL-1:0][SELW-1:0] sel,
    output logic                      bad
);

    // One extra bit so LIMIT == 2**SELW is representable.
    localparam logic [SELW:0] LIM = (SELW + 1)'(LIMIT);

    // Any out-of-range selector rejects the whole genotype.
    always_comb begin
        // NOTE: defaulting every comb output before the loop keeps this block free of latches.
        bad = 1'b0;
        for (int i = 0; i < NSEL; i++) begin
            if ({1'b0, sel[i]} >= LIM) begin
                bad = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chrom_serial_loader.sv
// chrom_serial_loader: serial-to-parallel genotype loader for the evolvable
// LUT grid. Bits are shifted into a shadow register; only a complete frame
// that passes the checks is copied to the committed outputs, so the grid
// never observes a partial genotype.
// Optional feature: define CHROM_PARITY_EN to append one even-parity bit to
// every frame and reject frames whose parity does not match.
module chrom_serial_loader
    import chrom_serial_loader_pkg::*;
#(
    parameter int ROW = chrom_serial_loader_pkg::ROW,
    parameter int COL = chrom_serial_loader_pkg::COL,
    parameter int OUT = chrom_serial_loader_pkg::OUT
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   s_valid,
    input  logic                                   s_bit,
    output logic                                   s_ready,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   err,
    output logic                                   chrom_valid,
    output logic [ROW-1:0][COL-1:0][15:0]          saidas_LE,
    output logic [OUT-1:0][$clog2(ROW*COL)-1:0]    out_chrom
);

    localparam int SELW  = $clog2(ROW * COL);
    localparam int CELLW = ROW * COL * 16;
    localparam int TOTAL = CELLW + OUT * SELW;
`ifdef CHROM_PARITY_EN
    localparam int FRAME = TOTAL + 1;
`else
    localparam int FRAME = TOTAL;
`endif
    localparam int CNTW  = $clog2(TOTAL + 2);

    loader_state_t    state;
    loader_state_t    state_nxt;
    logic [CNTW-1:0]  cnt;
    logic [TOTAL-1:0] shadow;
    logic             accept;
    logic             last_bit;
    logic             shift_en;
    logic             sel_bad;
    logic             frame_bad;
    logic             commit;

    // Restart has priority over a bit offered in the same cycle.
    assign accept   = (state == LD_SHIFT) && s_valid && !start;
    assign last_bit = accept && (cnt == CNTW'(FRAME - 1));
    // The trailing parity bit (when present) never enters the shadow register.
    assign shift_en = accept && (cnt < CNTW'(TOTAL));

    chrom_sel_check #(
        .NSEL  (OUT),
        .SELW  (SELW),
        .LIMIT (ROW * COL)
    ) u_sel_check (
        .sel (shadow[TOTAL-1:CELLW]),
        .bad (sel_bad)
    );

`ifdef CHROM_PARITY_EN
    logic par_acc;  // XOR of every accepted bit, parity bit included; 0 when even
    assign frame_bad = sel_bad | par_acc;
`else
    assign frame_bad = sel_bad;
`endif

    assign commit = (state == LD_CHECK) && !start && !frame_bad;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= LD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: start restarts the frame except during COMMIT.
    always_comb begin
        state_nxt = state;
        unique case (state)
            LD_IDLE:   if (start) state_nxt = LD_SHIFT;
            LD_SHIFT:  begin
                if (start)         state_nxt = LD_SHIFT;
                else if (last_bit) state_nxt = LD_CHECK;
            end
            LD_CHECK:  begin
                if (start)          state_nxt = LD_SHIFT;
                else if (frame_bad) state_nxt = LD_IDLE;
                else                state_nxt = LD_COMMIT;
            end
            LD_COMMIT: state_nxt = LD_IDLE;
            default:   state_nxt = LD_IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        s_ready = (state == LD_SHIFT);
        busy    = (state == LD_SHIFT) || (state == LD_CHECK);
        done    = (state == LD_COMMIT);
        err     = (state == LD_CHECK) && !start && frame_bad;
    end

    // Datapath: bit counter, shadow shift register and committed genotype.
    // The copy happens on entry to COMMIT so outputs and done appear together.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            shadow      <= '0;
            saidas_LE   <= '0;
            out_chrom   <= '0;
            chrom_valid <= 1'b0;
`ifdef CHROM_PARITY_EN
            par_acc     <= 1'b0;
`endif
        end else begin
            if (start && (state != LD_COMMIT)) begin
                cnt <= '0;
`ifdef CHROM_PARITY_EN
                par_acc <= 1'b0;
`endif
            end else if (accept) begin
                if (cnt != CNTW'(FRAME)) begin
                    cnt <= cnt + CNTW'(1);
                end
`ifdef CHROM_PARITY_EN
                par_acc <= par_acc ^ s_bit;
`endif
                if (shift_en) begin
                    shadow <= {s_bit, shadow[TOTAL-1:1]};
                end
            end
            if (commit) begin
                saidas_LE   <= shadow[CELLW-1:0];
                out_chrom   <= shadow[TOTAL-1:CELLW];
                chrom_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_chrom_serial_loader.sv
// Directed testbench for chrom_serial_loader. Instance dut_a uses the default
// 4x4 grid; dut_b uses a 3x3 grid so that a 4-bit selector can be out of range.
// Build with CHROM_PARITY_EN defined to exercise the parity frame format.
module tb_chrom_serial_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic start_a = 1'b0, valid_a = 1'b0, bit_a = 1'b0;
    logic ready_a, busy_a, done_a, err_a, cv_a;
    logic [3:0][3:0][15:0] sai_a;
    logic [1:0][3:0]       oc_a;

    logic start_b = 1'b0, valid_b = 1'b0, bit_b = 1'b0;
    logic ready_b, busy_b, done_b, err_b, cv_b;
    logic [2:0][2:0][15:0] sai_b;
    logic [1:0][3:0]       oc_b;

    int checks   = 0;
    int failures = 0;
    int done_cnt_a = 0, err_cnt_a = 0, done_cnt_b = 0, err_cnt_b = 0;

    logic [263:0] exp_a;
    logic [263:0] exp_b;

    always #5 clk = ~clk;

    chrom_serial_loader dut_a (
        .clk(clk), .rst(rst), .start(start_a), .s_valid(valid_a), .s_bit(bit_a),
        .s_ready(ready_a), .busy(busy_a), .done(done_a), .err(err_a),
        .chrom_valid(cv_a), .saidas_LE(sai_a), .out_chrom(oc_a)
    );

    chrom_serial_loader #(.ROW(3), .COL(3), .OUT(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .s_valid(valid_b), .s_bit(bit_b),
        .s_ready(ready_b), .busy(busy_b), .done(done_b), .err(err_b),
        .chrom_valid(cv_b), .saidas_LE(sai_b), .out_chrom(oc_b)
    );

    // Pulse counters; done/err are full-cycle pulses so the falling edge sees each once.
    always @(negedge clk) begin
        if (done_a) done_cnt_a++;
        if (err_a)  err_cnt_a++;
        if (done_b) done_cnt_b++;
        if (err_b)  err_cnt_b++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int which, input logic st, input logic v, input logic b);
        if (which == 0) begin
            start_a = st; valid_a = v; bit_a = b;
        end else begin
            start_b = st; valid_b = v; bit_b = b;
        end
    endtask

    task automatic pulse_start(input int which);
        drive(which, 1'b1, 1'b0, 1'b0);
        tick;
        drive(which, 1'b0, 1'b0, 1'b0);
    endtask

    // 4x4 frame: cell k (row-major) = base | k, then sel0, sel1.
    function automatic logic [263:0] frame_a(input logic [15:0] base, input logic [3:0] s0,
                                             input logic [3:0] s1);
        logic [263:0] f;
        f = '0;
        for (int k = 0; k < 16; k++) f[k*16 +: 16] = base | 16'(k);
        f[256 +: 4] = s0;
        f[260 +: 4] = s1;
        return f;
    endfunction

    // 3x3 frame: 9 cells then sel0, sel1 (152 payload bits).
    function automatic logic [263:0] frame_b(input logic [15:0] base, input logic [3:0] s0,
                                             input logic [3:0] s1);
        logic [263:0] f;
        f = '0;
        for (int k = 0; k < 9; k++) f[k*16 +: 16] = base | 16'(k);
        f[144 +: 4] = s0;
        f[148 +: 4] = s1;
        return f;
    endfunction

    // Stream n payload bits LSB first (plus parity when enabled). gap>0 drops
    // s_valid for one cycle before every gap-th bit; limit>=0 truncates the stream.
    task automatic send_frame(input logic [263:0] data, input int n, input int which,
                              input int gap, input bit bad_par, input int limit);
        int   len;
        logic par;
        logic b;
        par = 1'b0;
        for (int k = 0; k < n; k++) par = par ^ data[k];
        len = n;
`ifdef CHROM_PARITY_EN
        len = n + 1;
`endif
        if (limit >= 0 && limit < len) len = limit;
        for (int k = 0; k < len; k++) begin
            b = (k < n) ? data[k] : (par ^ bad_par);
            if (gap > 0 && (k % gap) == gap - 1) begin
                drive(which, 1'b0, 1'b0, 1'b0);
                tick;
            end
            drive(which, 1'b0, 1'b1, b);
            tick;
        end
        drive(which, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        checks++; if (sai_a !== '0) begin failures++; $display("FAIL reset_saidas got=%h exp=0", sai_a); end
        checks++; if (oc_a !== 8'h00) begin failures++; $display("FAIL reset_out_chrom got=%h exp=00", oc_a); end
        checks++; if ({ready_a, busy_a, done_a, err_a, cv_a} !== 5'b0) begin
            failures++; $display("FAIL reset_flags got=%b exp=00000", {ready_a, busy_a, done_a, err_a, cv_a}); end
        checks++; if ({ready_b, busy_b, cv_b, oc_b} !== 11'b0) begin
            failures++; $display("FAIL reset_b got=%h exp=0", {ready_b, busy_b, cv_b, oc_b}); end
        pulse_start(0);
        checks++; if ({ready_a, busy_a} !== 2'b11) begin
            failures++; $display("FAIL start_ready got=%b exp=11", {ready_a, busy_a}); end
    endtask

    task automatic test_clean_load;
        exp_a = frame_a(16'hA500, 4'h5, 4'hF);
        send_frame(exp_a, 264, 0, 0, 1'b0, -1);
        checks++; if ({done_a, busy_a} !== 2'b01) begin
            failures++; $display("FAIL clean_check_cycle got=%b exp=01", {done_a, busy_a}); end
        tick;
        checks++; if (done_a !== 1'b1) begin failures++; $display("FAIL clean_done_latency got=%b exp=1", done_a); end
        checks++; if (sai_a[2][3] !== 16'hA50B) begin failures++; $display("FAIL clean_cell23 got=%h exp=a50b", sai_a[2][3]); end
        checks++; if (oc_a !== 8'hF5) begin failures++; $display("FAIL clean_out_chrom got=%h exp=f5", oc_a); end
        checks++; if (sai_a !== exp_a[255:0]) begin failures++; $display("FAIL clean_saidas got=%h exp=%h", sai_a, exp_a[255:0]); end
        checks++; if (cv_a !== 1'b1) begin failures++; $display("FAIL clean_chrom_valid got=%b exp=1", cv_a); end
        tick;
        checks++; if ({done_a, busy_a, ready_a} !== 3'b000) begin
            failures++; $display("FAIL clean_idle got=%b exp=000", {done_a, busy_a, ready_a}); end
        checks++; if (done_cnt_a !== 1) begin failures++; $display("FAIL clean_done_count got=%0d exp=1", done_cnt_a); end
    endtask

    task automatic test_throttled;
        pulse_start(0);
        send_frame(exp_a, 264, 0, 5, 1'b0, -1);
        tick;
        checks++; if (done_a !== 1'b1) begin failures++; $display("FAIL thr_done got=%b exp=1", done_a); end
        checks++; if (sai_a !== exp_a[255:0] || oc_a !== 8'hF5) begin
            failures++; $display("FAIL thr_outputs got=%h/%h exp=%h/f5", sai_a, oc_a, exp_a[255:0]); end
        tick; tick;
        checks++; if (done_cnt_a !== 2) begin failures++; $display("FAIL thr_done_count got=%0d exp=2", done_cnt_a); end
    endtask

    task automatic test_abort;
        logic [263:0] frame_d;
        frame_d = frame_a(16'h5A00, 4'h7, 4'h9);
        pulse_start(0);
        send_frame(frame_a(16'h3C00, 4'h1, 4'h2), 264, 0, 0, 1'b0, 100);
        checks++; if (sai_a !== exp_a[255:0] || oc_a !== 8'hF5 || cv_a !== 1'b1) begin
            failures++; $display("FAIL abort_hold_mid got=%h/%h exp=%h/f5", sai_a, oc_a, exp_a[255:0]); end
        // Restart with a 1 offered in the same cycle: that bit must be dropped.
        drive(0, 1'b1, 1'b1, 1'b1);
        tick;
        drive(0, 1'b0, 1'b0, 1'b0);
        checks++; if (ready_a !== 1'b1 || sai_a !== exp_a[255:0]) begin
            failures++; $display("FAIL abort_restart got=%b/%h exp=1/%h", ready_a, sai_a, exp_a[255:0]); end
        send_frame(frame_d, 264, 0, 0, 1'b0, -1);
        checks++; if (sai_a !== exp_a[255:0]) begin
            failures++; $display("FAIL abort_hold_check got=%h exp=%h", sai_a, exp_a[255:0]); end
        tick;
        exp_a = frame_d;
        checks++; if (sai_a !== exp_a[255:0] || oc_a !== 8'h97) begin
            failures++; $display("FAIL abort_new_commit got=%h/%h exp=%h/97", sai_a, oc_a, exp_a[255:0]); end
        tick;
        checks++; if (done_cnt_a !== 3) begin failures++; $display("FAIL abort_done_count got=%0d exp=3", done_cnt_a); end
    endtask

    task automatic test_bad_selector;
        exp_b = frame_b(16'h1200, 4'h2, 4'h8);
        pulse_start(1);
        send_frame(exp_b, 152, 1, 0, 1'b0, -1);
        tick;
        checks++; if (done_b !== 1'b1 || oc_b !== 8'h82 || sai_b !== exp_b[143:0]) begin
            failures++; $display("FAIL bsel_good got=%b/%h exp=1/82", done_b, oc_b); end
        tick;
        pulse_start(1);
        send_frame(frame_b(16'h7700, 4'hC, 4'h1), 152, 1, 0, 1'b0, -1);
        checks++; if ({err_b, done_b} !== 2'b10) begin
            failures++; $display("FAIL bsel_err got=%b exp=10", {err_b, done_b}); end
        tick;
        checks++; if ({err_b, done_b, busy_b} !== 3'b000) begin
            failures++; $display("FAIL bsel_idle got=%b exp=000", {err_b, done_b, busy_b}); end
        checks++; if (sai_b !== exp_b[143:0] || oc_b !== 8'h82 || cv_b !== 1'b1) begin
            failures++; $display("FAIL bsel_hold got=%h/%h/%b exp=%h/82/1", sai_b, oc_b, cv_b, exp_b[143:0]); end
        checks++; if (err_cnt_b !== 1 || done_cnt_b !== 1) begin
            failures++; $display("FAIL bsel_counts got=%0d/%0d exp=1/1", err_cnt_b, done_cnt_b); end
    endtask

`ifdef CHROM_PARITY_EN
    task automatic test_parity;
        logic [263:0] frame_c;
        frame_c = frame_a(16'hA500, 4'h5, 4'hF);
        pulse_start(0);
        send_frame(frame_c, 264, 0, 0, 1'b1, -1);
        checks++; if ({err_a, done_a} !== 2'b10) begin
            failures++; $display("FAIL par_bad_err got=%b exp=10", {err_a, done_a}); end
        tick; tick;
        checks++; if (sai_a !== exp_a[255:0] || done_cnt_a !== 3) begin
            failures++; $display("FAIL par_bad_hold got=%h/%0d exp=%h/3", sai_a, done_cnt_a, exp_a[255:0]); end
        pulse_start(0);
        send_frame(frame_c, 264, 0, 0, 1'b0, 264);
        checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL par_wait_bit got=%b exp=1", ready_a); end
        pulse_start(0);
        send_frame(frame_c, 264, 0, 0, 1'b0, -1);
        tick;
        exp_a = frame_c;
        checks++; if (done_a !== 1'b1 || sai_a !== exp_a[255:0] || oc_a !== 8'hF5) begin
            failures++; $display("FAIL par_good got=%b/%h exp=1/f5", done_a, oc_a); end
        tick;
    endtask
`endif

    task automatic test_reset_midframe;
        pulse_start(0);
        send_frame(exp_a, 264, 0, 0, 1'b0, 50);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++; if (sai_a !== '0 || oc_a !== 8'h00) begin
            failures++; $display("FAIL rstmid_outputs got=%h/%h exp=0/00", sai_a, oc_a); end
        checks++; if ({ready_a, busy_a, cv_a} !== 3'b000) begin
            failures++; $display("FAIL rstmid_flags got=%b exp=000", {ready_a, busy_a, cv_a}); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_clean_load;
        test_throttled;
        test_abort;
        test_bad_selector;
`ifdef CHROM_PARITY_EN
        test_parity;
`endif
        test_reset_midframe;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
